// File: rtl/fib_pkg.sv
// Shared Fibonacci helpers, widths and FSM encoding for the Fibonacci-coded arithmetic blocks.
// W_MIN/W_MAX bound the operand digit count for which BW-bit arithmetic never wraps.
package fib_pkg;

  localparam int W_MIN = 4;
  localparam int W_MAX = 60;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    COMBINE,
    CONV,
    DONE
  } state_e;

  // fib(1) = fib(2) = 1
  function automatic logic [63:0] fib(input int n);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // ceil(log2(2*F(w+2))) + 1
  function automatic int fib_bw(input int w);
    logic [63:0] v;
    int n;
    v = fib(w + 2) << 1;
    n = 0;
    for (int b = 0; b < 63; b++) begin
      if ((64'd1 << b) < v) n = b + 1;
    end
    return n + 1;
  endfunction

endpackage

// File: rtl/fib_addsub_param_if.sv
// Start/done handshake and operand/result bundle for the Fibonacci adder/subtractor.
interface fib_addsub_param_if #(
  parameter int W = 32
) ();

  logic         en_sum;
  logic         mode;
  logic [W-1:0] input_i;
  logic [W-1:0] input_j;
  logic [W-1:0] out_sum;
  logic         sum_done;
  logic         busy;
  logic         ovf;
  logic         nonnorm;

  modport master (
    output en_sum, mode, input_i, input_j,
    input  out_sum, sum_done, busy, ovf, nonnorm
  );

  modport slave (
    input  en_sum, mode, input_i, input_j,
    output out_sum, sum_done, busy, ovf, nonnorm
  );

endinterface

// File: rtl/zeck_greedy_step.sv
// One greedy Zeckendorf digit: emits 1 when the remainder covers the current Fibonacci
// weight, then steps the descending weight pair down by one index.
module zeck_greedy_step #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] r_i,
  input  logic [BW-1:0] g_i,
  input  logic [BW-1:0] gHi_i,
  output logic          digit_o,
  output logic [BW-1:0] r_o,
  output logic [BW-1:0] g_o,
  output logic [BW-1:0] gHi_o
);

  assign digit_o = (r_i >= g_i);
  assign r_o     = digit_o ? (r_i - g_i) : r_i;
  assign g_o     = gHi_i - g_i;
  assign gHi_o   = g_i;

endmodule

// File: rtl/fib_addsub_param.sv
// Parametrised Fibonacci-coded adder/subtractor: decodes both operands to binary, adds or
// subtracts, then re-encodes greedily into Zeckendorf normal form. Fixed 2W+2 cycle latency.
module fib_addsub_param
  import fib_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fib_addsub_param_if.slave     bus
);

  localparam int              BW     = fib_bw(W);
  localparam int              KW     = $clog2(W);
  localparam logic [KW-1:0]   K_LAST = KW'(W - 1);

  if (W < W_MIN || W > W_MAX) begin : gBadWidth
    $error("fib_addsub_param: W outside legal range");
  end

  state_e         state_q;
  state_e         state_d;
  logic [W-1:0]   opI_q;
  logic [W-1:0]   opJ_q;
  logic           mode_q;
  logic [BW-1:0]  accA_q;
  logic [BW-1:0]  accB_q;
  logic [BW-1:0]  f_q;
  logic [BW-1:0]  fPrev_q;
  logic [BW-1:0]  r_q;
  logic [BW-1:0]  g_q;
  logic [BW-1:0]  gHi_q;
  logic [KW-1:0]  k_q;
  logic           nonnormAcc_q;
  logic           ovfRes_q;
  logic [W-1:0]   z_q;
  logic [W-1:0]   outSum_q;
  logic           sumDone_q;
  logic           ovf_q;
  logic           nonnorm_q;

  logic [BW-1:0]  sumAB;
  logic           digit;
  logic [BW-1:0]  rNext;
  logic [BW-1:0]  gNext;
  logic [BW-1:0]  gHiNext;

  assign sumAB = accA_q + accB_q;

  zeck_greedy_step #(.BW(BW)) uStep (
    .r_i    (r_q),
    .g_i    (g_q),
    .gHi_i  (gHi_q),
    .digit_o(digit),
    .r_o    (rNext),
    .g_o    (gNext),
    .gHi_o  (gHiNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.en_sum) state_d = ACC;
      ACC:     if (k_q == K_LAST) state_d = COMBINE;
      COMBINE: state_d = CONV;
      CONV:    if (k_q == K_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift right so digit k is always at bit 0; bit 1 then gives the adjacency test.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opI_q        <= '0;
      opJ_q        <= '0;
      mode_q       <= 1'b0;
      accA_q       <= '0;
      accB_q       <= '0;
      f_q          <= '0;
      fPrev_q      <= '0;
      r_q          <= '0;
      g_q          <= '0;
      gHi_q        <= '0;
      k_q          <= '0;
      nonnormAcc_q <= 1'b0;
      ovfRes_q     <= 1'b0;
      z_q          <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.en_sum) begin
            opI_q        <= bus.input_i;
            opJ_q        <= bus.input_j;
            mode_q       <= bus.mode;
            accA_q       <= '0;
            accB_q       <= '0;
            f_q          <= BW'(1);
            fPrev_q      <= BW'(1);
            k_q          <= '0;
            nonnormAcc_q <= 1'b0;
          end
        end
        ACC: begin
          accA_q       <= accA_q + (opI_q[0] ? f_q : '0);
          accB_q       <= accB_q + (opJ_q[0] ? f_q : '0);
          f_q          <= f_q + fPrev_q;
          fPrev_q      <= f_q;
          opI_q        <= opI_q >> 1;
          opJ_q        <= opJ_q >> 1;
          nonnormAcc_q <= nonnormAcc_q | (opI_q[0] & opI_q[1]) | (opJ_q[0] & opJ_q[1]);
          k_q          <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
        COMBINE: begin
          if (!mode_q) begin
            r_q      <= sumAB;
            ovfRes_q <= (sumAB >= f_q);
          end else begin
            r_q      <= (accA_q < accB_q) ? '0 : (accA_q - accB_q);
            ovfRes_q <= (accA_q < accB_q);
          end
          g_q   <= fPrev_q;
          gHi_q <= f_q;
          k_q   <= '0;
        end
        CONV: begin
          r_q   <= rNext;
          g_q   <= gNext;
          gHi_q <= gHiNext;
          z_q   <= {z_q[W-2:0], digit & ~ovfRes_q};
          k_q   <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outSum_q  <= '0;
      sumDone_q <= 1'b0;
      ovf_q     <= 1'b0;
      nonnorm_q <= 1'b0;
    end else begin
      sumDone_q <= (state_q == DONE);
      if (state_q == DONE) begin
        outSum_q  <= z_q;
        ovf_q     <= ovfRes_q;
        nonnorm_q <= nonnormAcc_q;
      end
    end
  end

  assign bus.out_sum  = outSum_q;
  assign bus.sum_done = sumDone_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.ovf      = ovf_q;
  assign bus.nonnorm  = nonnorm_q;

endmodule

// File: tb/tb_fib_addsub_param.sv
// Self-checking bench for fib_addsub_param at W=32 and W=4: directed cases plus randomized
// operations compared against a value-level Fibonacci/Zeckendorf reference model.
module tb_fib_addsub_param;

  logic clk;
  logic rst;

  int errCount   = 0;
  int checkCount = 0;

  logic [63:0] fibT [0:70];

  logic [63:0] lastRes;
  logic        lastOvf;
  logic        lastNn;
  int          lastLat;

  fib_addsub_param_if #(.W(32)) b32 ();
  fib_addsub_param_if #(.W(4))  b4  ();

  fib_addsub_param #(.W(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  fib_addsub_param #(.W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] codeValue(input logic [63:0] c, input int w);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < w; k++) if (c[k]) v = v + fibT[k + 2];
    return v;
  endfunction

  function automatic logic [63:0] zeckOf(input logic [63:0] v, input int w);
    logic [63:0] z;
    logic [63:0] rem;
    z   = 64'd0;
    rem = v;
    for (int k = w - 1; k >= 0; k--) begin
      if (rem >= fibT[k + 2]) begin
        z[k] = 1'b1;
        rem  = rem - fibT[k + 2];
      end
    end
    return z;
  endfunction

  function automatic logic adjOnes(input logic [63:0] c, input int w);
    logic a;
    a = 1'b0;
    for (int k = 0; k < w - 1; k++) if (c[k] && c[k + 1]) a = 1'b1;
    return a;
  endfunction

  function automatic logic [63:0] randOperand(input int w);
    logic [63:0] r;
    if ($urandom_range(0, 1) == 1) r = zeckOf(64'($urandom) % fibT[w + 2], w);
    else                           r = {$urandom, $urandom} & ((64'd1 << w) - 64'd1);
    return r;
  endfunction

  function automatic logic doneOf(input int w);
    return (w == 32) ? b32.sum_done : b4.sum_done;
  endfunction

  function automatic logic busyOf(input int w);
    return (w == 32) ? b32.busy : b4.busy;
  endfunction

  function automatic logic [63:0] outOf(input int w);
    return (w == 32) ? 64'(b32.out_sum) : 64'(b4.out_sum);
  endfunction

  function automatic logic ovfOf(input int w);
    return (w == 32) ? b32.ovf : b4.ovf;
  endfunction

  function automatic logic nnOf(input int w);
    return (w == 32) ? b32.nonnorm : b4.nonnorm;
  endfunction

  task automatic driveIn(input int w, input logic md, input logic [63:0] a, input logic [63:0] b,
                         input logic en);
    if (w == 32) begin
      b32.mode    = md;
      b32.input_i = a[31:0];
      b32.input_j = b[31:0];
      b32.en_sum  = en;
    end else begin
      b4.mode    = md;
      b4.input_i = a[3:0];
      b4.input_j = b[3:0];
      b4.en_sum  = en;
    end
  endtask

  // Starts one operation and returns in the sum_done cycle; operands are scrambled while busy.
  task automatic applyStimulus(input int w, input logic md, input logic [63:0] a,
                               input logic [63:0] b, input bit chain, input bit pulseBusy);
    if (!chain) @(negedge clk);
    driveIn(w, md, a, b, 1'b1);
    @(posedge clk);
    #1;
    driveIn(w, md, a, b, 1'b0);
    checkOutput("busyRise", 64'(busyOf(w)), 64'd1);
    lastLat = -1;
    for (int n = 1; n <= 2 * w + 20; n++) begin
      @(posedge clk);
      #1;
      if (doneOf(w)) begin
        lastLat = n;
        break;
      end
      driveIn(w, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
              pulseBusy && (n == 5 || n == 20));
    end
    checkOutput("latency", 64'(lastLat), 64'(2 * w + 2));
    checkOutput("busyFall", 64'(busyOf(w)), 64'd0);
    lastRes = outOf(w);
    lastOvf = ovfOf(w);
    lastNn  = nnOf(w);
  endtask

  task automatic countDones(input int w, input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (doneOf(w)) cnt++;
    end
  endtask

  task automatic checkModelOp(input string tag, input int w, input logic md,
                              input logic [63:0] a, input logic [63:0] b);
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] r;
    logic        ov;
    applyStimulus(w, md, a, b, 1'b0, 1'b0);
    va = codeValue(a, w);
    vb = codeValue(b, w);
    if (!md) begin
      r  = va + vb;
      ov = (r >= fibT[w + 2]);
    end else begin
      ov = (va < vb);
      r  = va - vb;
    end
    checkOutput({tag, ".sum"}, lastRes, ov ? 64'd0 : zeckOf(r, w));
    checkOutput({tag, ".ovf"}, 64'(lastOvf), 64'(ov));
    checkOutput({tag, ".nonnorm"}, 64'(lastNn), 64'(adjOnes(a, w) | adjOnes(b, w)));
    @(posedge clk);
    #1;
    checkOutput({tag, ".doneOneShot"}, 64'(doneOf(w)), 64'd0);
  endtask

  initial begin
    int cnt;
    fibT[0] = 64'd0;
    fibT[1] = 64'd1;
    for (int n = 2; n <= 70; n++) fibT[n] = fibT[n - 1] + fibT[n - 2];

    rst = 1'b0;
    driveIn(32, 1'b0, 64'd0, 64'd0, 1'b0);
    driveIn(4, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.out32", outOf(32), 64'd0);
    checkOutput("rst.done32", 64'(doneOf(32)), 64'd0);
    checkOutput("rst.busy32", 64'(busyOf(32)), 64'd0);
    checkOutput("rst.ovf32", 64'(ovfOf(32)), 64'd0);
    checkOutput("rst.nn32", 64'(nnOf(32)), 64'd0);
    checkOutput("rst.busy4", 64'(busyOf(4)), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(32, 1'b0, 64'b100, 64'b100, 1'b0, 1'b0);
    checkOutput("add3p3.sum", lastRes, 64'b1001);
    checkOutput("add3p3.ovf", 64'(lastOvf), 64'd0);
    checkOutput("add3p3.nn", 64'(lastNn), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("add3p3.doneOneShot", 64'(doneOf(32)), 64'd0);

    applyStimulus(32, 1'b1, 64'b10000, 64'b1, 1'b0, 1'b0);
    checkOutput("sub8m1.sum", lastRes, 64'b1010);
    checkOutput("sub8m1.ovf", 64'(lastOvf), 64'd0);

    applyStimulus(32, 1'b1, 64'b1, 64'b10, 1'b0, 1'b0);
    checkOutput("sub1m2.sum", lastRes, 64'd0);
    checkOutput("sub1m2.ovf", 64'(lastOvf), 64'd1);

    applyStimulus(4, 1'b0, 64'b1010, 64'b0001, 1'b0, 1'b0);
    checkOutput("w4ovf.sum", lastRes, 64'd0);
    checkOutput("w4ovf.ovf", 64'(lastOvf), 64'd1);

    applyStimulus(4, 1'b0, 64'b1000, 64'b0001, 1'b0, 1'b0);
    checkOutput("w4add.sum", lastRes, 64'b1001);
    checkOutput("w4add.ovf", 64'(lastOvf), 64'd0);

    applyStimulus(32, 1'b0, 64'b11, 64'd0, 1'b0, 1'b0);
    checkOutput("nonnorm.sum", lastRes, 64'b100);
    checkOutput("nonnorm.nn", 64'(lastNn), 64'd1);

    applyStimulus(32, 1'b0, 64'b101, 64'b10, 1'b0, 1'b1);
    checkOutput("busyPulse.sum", lastRes, 64'b1001);
    countDones(32, 2 * 32 + 10, cnt);
    checkOutput("busyPulse.extraDone", 64'(cnt), 64'd0);

    applyStimulus(32, 1'b0, 64'b1, 64'b1, 1'b0, 1'b0);
    checkOutput("b2bFirst.sum", lastRes, 64'b10);
    applyStimulus(32, 1'b1, 64'b100000, 64'b100, 1'b1, 1'b0);
    checkOutput("b2bSecond.sum", lastRes, 64'b10010);
    checkOutput("b2bSecond.gap", 64'(lastLat + 1), 64'(2 * 32 + 3));

    @(negedge clk);
    driveIn(32, 1'b0, 64'b1000, 64'b1, 1'b1);
    @(posedge clk);
    #1;
    driveIn(32, 1'b0, 64'b1000, 64'b1, 1'b0);
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midRst.out", outOf(32), 64'd0);
    checkOutput("midRst.busy", 64'(busyOf(32)), 64'd0);
    checkOutput("midRst.done", 64'(doneOf(32)), 64'd0);
    checkOutput("midRst.ovf", 64'(ovfOf(32)), 64'd0);
    checkOutput("midRst.nn", 64'(nnOf(32)), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    countDones(32, 2 * 32 + 10, cnt);
    checkOutput("midRst.noDone", 64'(cnt), 64'd0);
    checkModelOp("afterRst", 32, 1'b0, 64'b1000, 64'b1);

    for (int t = 0; t < 30; t++) begin
      checkModelOp("rand32", 32, 1'($urandom_range(0, 1)), randOperand(32), randOperand(32));
    end
    for (int t = 0; t < 30; t++) begin
      checkModelOp("rand4", 4, 1'($urandom_range(0, 1)), randOperand(4), randOperand(4));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
